// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_ld_state_t;

    // Bit counter width. Sized for the two-pass readback load so that the
    // counter never wraps, even when its final increment reaches TOTAL.
    function automatic int cnt_w(input int chain_len);
        return $clog2(2 * chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_tail_checker.sv
// Sticky readback comparator: flags any pass-2 shift where the bit leaving the chain differs from the bit entering it.
// Latency: err rises one cycle after the mismatching shift cycle.
// Backpressure: none; it samples every cycle and never stalls the loader.
//
// Ports: prog_clk/pReset (sync, active-high), clear (sync clear on a new
// load), pass2 (second pass of the image in progress), shift_en/ccff_head
// (bit entering the chain this cycle), ccff_tail (bit leaving the chain),
// err (sticky mismatch flag).
module ccff_tail_checker (
    input  logic prog_clk,
    input  logic pReset,
    input  logic clear,
    input  logic pass2,
    input  logic shift_en,
    input  logic ccff_head,
    input  logic ccff_tail,
    output logic err
);

    // In pass 2 the bit at the tail is the pass-1 copy of the very bit now
    // entering at the head, so any inequality means a corrupted chain.
    always_ff @(posedge prog_clk) begin
        if (pReset || clear) begin
            err <= 1'b0;
        end else if (pass2 && shift_en && (ccff_tail != ccff_head)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream words onto the ccff_head configuration chain, LSB first, with a per-cycle shift enable.
// Latency: word accepted at t drives its first bit at t+1; each word costs 1 fetch cycle + its shift cycles; done follows the last shift.
// Backpressure: cfg_ready is high only in FETCH; a low cfg_valid stalls the load in FETCH indefinitely with the chain frozen.
//
// Optional feature macro: CCFF_READBACK_CHECK_EN (image sent twice, pass 2
// compared bit-for-bit against ccff_tail, mismatch reported on sticky err).
//
// Ports: prog_clk (only clock), pReset (sync, active-high), start (begin a
// load when idle), cfg_valid/cfg_ready/cfg_data (word handshake), ccff_head
// (serial data into chain), ccff_tail (serial data out of chain), shift_en
// (chain advances at end of cycle), busy, done (1-cycle pulse), err.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 22,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = cnt_w(CHAIN_LEN);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

`ifdef CCFF_READBACK_CHECK_EN
    localparam int TOTAL = 2 * CHAIN_LEN;
`else
    localparam int TOTAL = CHAIN_LEN;
`endif

    localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] PASS_END = CW'(CHAIN_LEN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    ccff_ld_state_t    state;
    ccff_ld_state_t    state_nxt;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bidx;
    logic [WORD_W-1:0] sr;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en  = 1'b1;
                ccff_head = sr[0];
                // End of a pass forces a fresh word even mid-word, so the
                // high bits of the last word of each pass are dropped and
                // pass 2 starts word-aligned. In a single-pass build the
                // pass end coincides with CNT_LAST, which wins.
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else if ((bidx == BIT_LAST) || (cnt == PASS_END)) begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. The chain itself is not cleared on reset: partially shifted
    // contents are left for the next full load to overwrite.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cnt  <= '0;
            bidx <= '0;
            sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                FETCH: begin
                    if (cfg_valid) begin
                        sr   <= cfg_data;
                        bidx <= '0;
                    end
                end
                SHIFT: begin
                    sr   <= sr >> 1;
                    cnt  <= cnt + 1'b1;
                    bidx <= bidx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CCFF_READBACK_CHECK_EN
    logic pass2;
    logic err_clr;

    assign pass2   = (cnt >= CW'(CHAIN_LEN));
    assign err_clr = (state == IDLE) && start;

    ccff_tail_checker u_tail_checker (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .clear     (err_clr),
        .pass2     (pass2),
        .shift_en  (shift_en),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .err       (err)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err         = 1'b0;
`endif

endmodule
